// File: rtl/vector_ls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_ls_pkg
//  Description : Shared types, constants and sizing helpers for the vector
//                load/store control FSM, its interface and the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package vector_ls_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } State;

    // Bytes per bus word; every scalar transfer advances the address by this
    localparam int unsigned WORD_BYTES = 4;

    // Number of bus words that make up one full vector register
    function automatic int calc_num_scalars(input int num_slices, input int num_elems,
                                            input int elem_size, input int scalar_size);
        return (num_slices * num_elems * elem_size) / scalar_size;
    endfunction

    // Width able to hold a count of 0..num_scalars inclusive
    function automatic int calc_cw(input int num_scalars);
        return $clog2(num_scalars + 1);
    endfunction

    // Width of a scalar index 0..num_scalars-1, never below one bit
    function automatic int calc_iw(input int num_scalars);
        return (num_scalars <= 1) ? 1 : $clog2(num_scalars);
    endfunction

endpackage : vector_ls_pkg
`default_nettype wire

// File: rtl/vector_ls_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vector_ls_seq
//  Description : Vector load/store sequencer. Turns one load/store command into
//                'count' word transactions between the data memory port and the
//                vector register file. Loads are pipelined with in-order
//                responses; stores are posted. Signals completion with a
//                single-cycle 'complete' pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_ls_seq
    import vector_ls_pkg::*;
#(
    parameter  int NUM_SLICES  = 1,
    parameter  int NUM_ELEMS   = 8,
    parameter  int ELEM_SIZE   = 16,
    parameter  int SCALAR_SIZE = 32,
    localparam int NUM_SCALARS = calc_num_scalars(NUM_SLICES, NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE),
    localparam int CW          = calc_cw(NUM_SCALARS),
    localparam int IW          = calc_iw(NUM_SCALARS)
) (
    input  logic                   clk,
    input  logic                   reset,
    // Command from the load/store control FSM
    input  logic                   new_op,
    input  logic                   we,
    input  logic                   store_en,
    input  logic [CW-1:0]          count,
    input  logic [31:0]            g,
    output logic                   complete,
    // Data memory port
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [SCALAR_SIZE-1:0] mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [SCALAR_SIZE-1:0] mem_rdata,
    // Vector register file
    output logic [IW-1:0]          vr_rd_idx,
    input  logic [SCALAR_SIZE-1:0] vr_rd_data,
    output logic                   vr_wr_en,
    output logic [IW-1:0]          vr_wr_idx,
    output logic [SCALAR_SIZE-1:0] vr_wr_data
);

    localparam logic [CW-1:0] c_max_count = CW'(NUM_SCALARS);
    localparam logic [CW-1:0] c_one       = CW'(1);

    State          r_state, w_next_state;
    logic [31:0]   r_base,  w_next_base;
    logic [CW-1:0] r_cnt,   w_next_cnt;
    logic [CW-1:0] r_iss_idx, w_next_iss_idx;   // requests granted so far
    logic [CW-1:0] r_ret_idx, w_next_ret_idx;   // load responses written so far

    logic          w_busy;
    logic          w_issue;
    logic          w_rv_accept;
    logic [CW-1:0] w_iss_inc;
    logic [CW-1:0] w_ret_inc;
    logic [CW-1:0] w_count_clamped;

    assign w_busy          = (r_state == S_LOAD) || (r_state == S_STORE);
    assign w_issue         = w_busy && (r_iss_idx < r_cnt);
    assign w_iss_inc       = r_iss_idx + c_one;
    assign w_ret_inc       = r_ret_idx + c_one;
    assign w_count_clamped = (count > c_max_count) ? c_max_count : count;
    // A response with nothing outstanding cannot belong to any request; drop it
    assign w_rv_accept     = (r_state == S_LOAD) && mem_rvalid && (r_ret_idx != r_iss_idx);

    // State register, base address and both index counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_cnt     <= '0;
            r_iss_idx <= '0;
            r_ret_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_base    <= w_next_base;
            r_cnt     <= w_next_cnt;
            r_iss_idx <= w_next_iss_idx;
            r_ret_idx <= w_next_ret_idx;
        end
    end

    // Next-state, counter updates and handshake outputs
    always_comb begin
        w_next_state   = r_state;
        w_next_base    = r_base;
        w_next_cnt     = r_cnt;
        w_next_iss_idx = r_iss_idx;
        w_next_ret_idx = r_ret_idx;
        complete       = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        vr_wr_en       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (new_op) begin
                    w_next_base    = g & ~32'h3;
                    w_next_cnt     = w_count_clamped;
                    w_next_iss_idx = '0;
                    w_next_ret_idx = '0;
                    if (count == '0) begin
                        w_next_state = S_DONE;
                    end else if (we && store_en) begin
                        w_next_state = S_STORE;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end
            end
            S_STORE: begin
                mem_req = w_issue;
                mem_we  = w_issue;
                if (w_issue && mem_gnt) begin
                    w_next_iss_idx = w_iss_inc;
                    if (w_iss_inc == r_cnt) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                mem_req = w_issue;
                if (w_issue && mem_gnt) begin
                    w_next_iss_idx = w_iss_inc;
                end
                if (w_rv_accept) begin
                    vr_wr_en       = 1'b1;
                    w_next_ret_idx = w_ret_inc;
                    if (w_ret_inc == r_cnt) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                complete     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Address and index outputs follow registered state only, so a stalled
    // grant keeps them stable. Data pass-throughs are gated so that they
    // idle at zero.
    assign mem_addr   = r_base + 32'(r_iss_idx) * WORD_BYTES;
    assign vr_rd_idx  = r_iss_idx[IW-1:0];
    assign mem_wdata  = mem_we   ? vr_rd_data : '0;
    assign vr_wr_idx  = r_ret_idx[IW-1:0];
    assign vr_wr_data = vr_wr_en ? mem_rdata  : '0;

endmodule : vector_ls_seq
`default_nettype wire

// File: tb/tb_vector_ls_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_ls_seq
//  Description : Self-checking bench for vector_ls_seq with a scoreboard of
//                expected bus requests, register-file writes and completions,
//                plus a simple memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_ls_seq;

    localparam int NS = 4;
    localparam int CW = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_op, we, store_en;
    logic [CW-1:0] count;
    logic [31:0]   g;
    logic          complete;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_gnt, mem_rvalid;
    logic [31:0]   mem_rdata;
    logic [IW-1:0] vr_rd_idx;
    logic [31:0]   vr_rd_data;
    logic          vr_wr_en;
    logic [IW-1:0] vr_wr_idx;
    logic [31:0]   vr_wr_data;

    always #5 clk = ~clk;

    // Register-file read model: scalar i holds i * 0x11111111
    assign vr_rd_data = 32'(vr_rd_idx) * 32'h1111_1111;

    vector_ls_seq dut (
        .clk        (clk),
        .reset      (reset),
        .new_op     (new_op),
        .we         (we),
        .store_en   (store_en),
        .count      (count),
        .g          (g),
        .complete   (complete),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .vr_rd_idx  (vr_rd_idx),
        .vr_rd_data (vr_rd_data),
        .vr_wr_en   (vr_wr_en),
        .vr_wr_idx  (vr_wr_idx),
        .vr_wr_data (vr_wr_data)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } bus_t;
    typedef struct { logic [IW-1:0] idx; logic [31:0] data; } vr_t;
    typedef struct { int due; logic [31:0] data; } rv_t;

    bus_t        exp_bus[$];
    vr_t         exp_vr[$];
    int          exp_cmp[$];
    rv_t         rv_q[$];
    logic [31:0] ld_q[$];

    int cyc      = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    int rv_delay = 1;
    int stall_lo = -1;
    int stall_hi = -2;
    bit mon_en   = 1'b0;

    bit            pend_op  = 1'b0;
    bit            pend_rst = 1'b1;
    logic          pend_we  = 1'b0;
    logic          pend_se  = 1'b0;
    logic [CW-1:0] pend_cnt = '0;
    logic [31:0]   pend_g   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".complete"},   32'(complete),   0);
        chk({tag, ".mem_req"},    32'(mem_req),    0);
        chk({tag, ".mem_we"},     32'(mem_we),     0);
        chk({tag, ".mem_addr"},   mem_addr,        0);
        chk({tag, ".mem_wdata"},  mem_wdata,       0);
        chk({tag, ".vr_rd_idx"},  32'(vr_rd_idx),  0);
        chk({tag, ".vr_wr_en"},   32'(vr_wr_en),   0);
        chk({tag, ".vr_wr_idx"},  32'(vr_wr_idx),  0);
        chk({tag, ".vr_wr_data"}, vr_wr_data,      0);
    endtask

    // Compares DUT outputs of the current cycle against the scoreboard
    task automatic monitor();
        rv_t r;
        if (!mon_en) return;
        if (mem_req) begin
            if (exp_bus.size() > 0) begin
                chk("mem_addr", mem_addr, exp_bus[0].addr);
                chk("mem_we", 32'(mem_we), 32'(exp_bus[0].we));
                if (exp_bus[0].we) chk("mem_wdata", mem_wdata, exp_bus[0].data);
                if (mem_gnt) begin
                    if (!exp_bus[0].we && ld_q.size() > 0) begin
                        r.due  = cyc + rv_delay;
                        r.data = ld_q.pop_front();
                        rv_q.push_back(r);
                    end
                    void'(exp_bus.pop_front());
                end
            end else begin
                chk("mem_req_unexp", 32'(mem_req), 0);
            end
        end
        if (vr_wr_en) begin
            if (exp_vr.size() > 0) begin
                chk("vr_wr_idx", 32'(vr_wr_idx), 32'(exp_vr[0].idx));
                chk("vr_wr_data", vr_wr_data, exp_vr[0].data);
                void'(exp_vr.pop_front());
            end else begin
                chk("vr_wr_unexp", 32'(vr_wr_en), 0);
            end
        end
        if (exp_cmp.size() > 0 && exp_cmp[0] == cyc) begin
            chk("complete", 32'(complete), 1);
            void'(exp_cmp.pop_front());
        end else if (complete) begin
            chk("complete_unexp", 32'(complete), 0);
        end
    endtask

    // One clock cycle: drive inputs shortly after the edge, sample mid-cycle
    task automatic cycle();
        @(posedge clk);
        cyc++;
        #2;
        reset    = pend_rst;
        new_op   = pend_op;
        we       = pend_we;
        store_en = pend_se;
        count    = pend_cnt;
        g        = pend_g;
        pend_op  = 1'b0;
        mem_gnt  = !(cyc >= stall_lo && cyc <= stall_hi);
        if (rv_q.size() > 0 && rv_q[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_q[0].data;
            void'(rv_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        #3;
        monitor();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Queue a store command for the next cycle; rel = completion offset
    task automatic store_op(input logic [31:0] ga, input int cnt, input int rel);
        bus_t b;
        int n;
        n = (cnt > NS) ? NS : cnt;
        for (int i = 0; i < n; i++) begin
            b.addr = (ga & ~32'h3) + 32'(4 * i);
            b.we   = 1'b1;
            b.data = 32'(i) * 32'h1111_1111;
            exp_bus.push_back(b);
        end
        pend_op = 1'b1; pend_we = 1'b1; pend_se = 1'b1;
        pend_cnt = CW'(cnt); pend_g = ga;
        if (rel >= 0) exp_cmp.push_back(cyc + 1 + rel);
    endtask

    // Queue a load command for the next cycle; load data is dbase+i
    task automatic load_op(input logic [31:0] ga, input int cnt, input int rel,
                           input logic [31:0] dbase);
        bus_t b;
        vr_t  v;
        int n;
        n = (cnt > NS) ? NS : cnt;
        for (int i = 0; i < n; i++) begin
            b.addr = (ga & ~32'h3) + 32'(4 * i);
            b.we   = 1'b0;
            b.data = '0;
            exp_bus.push_back(b);
            ld_q.push_back(dbase + 32'(i));
            v.idx  = IW'(i);
            v.data = dbase + 32'(i);
            exp_vr.push_back(v);
        end
        pend_op = 1'b1; pend_we = 1'b0; pend_se = 1'b0;
        pend_cnt = CW'(cnt); pend_g = ga;
        if (rel >= 0) exp_cmp.push_back(cyc + 1 + rel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1; new_op = 1'b0; we = 1'b0; store_en = 1'b0;
        count = '0; g = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        run(2);
        mon_en = 1'b1;
        check_zero("reset");
        pend_rst = 1'b0;
        run(1);

        // Store, always granted: complete 5 cycles after new_op
        store_op(32'h0000_1000, 4, 5);
        run(7);

        // Load, rvalid one cycle after grant, misaligned base
        load_op(32'h0000_2003, 4, 6, 32'hA000_00A0);
        run(8);

        // Load with a two-cycle grant stall on the second request
        stall_lo = cyc + 1 + 2;
        stall_hi = cyc + 1 + 3;
        load_op(32'h0000_2000, 4, 8, 32'hB000_0000);
        run(10);
        stall_lo = -1; stall_hi = -2;

        // count = 0: completion next cycle, no bus or vector activity
        load_op(32'h0000_7000, 0, 1, 32'h0);
        run(3);

        // Second new_op during a store is ignored
        store_op(32'h0000_3000, 4, 5);
        run(2);
        pend_op = 1'b1; pend_we = 1'b0; pend_se = 1'b0;
        pend_cnt = CW'(2); pend_g = 32'h0000_5000;
        run(5);

        // Address wrap and count clamp
        store_op(32'hFFFF_FFF8, 7, 5);
        run(7);

        // Reset mid-load after two grants; responses arrive late
        rv_delay = 3;
        t0 = cyc + 1;
        stall_lo = t0 + 3;
        stall_hi = t0 + 3;
        load_op(32'h0000_4000, 4, -1, 32'hC000_0000);
        run(3);
        pend_rst = 1'b1;
        run(1);
        exp_bus.delete();
        exp_vr.delete();
        ld_q.delete();
        pend_rst = 1'b0;
        run(1);
        check_zero("rst_mid");
        run(1);
        chk("late_rv_drained", 32'(rv_q.size()), 0);
        rv_delay = 1;
        stall_lo = -1; stall_hi = -2;
        load_op(32'h0000_6000, 4, 6, 32'hD000_0000);
        run(8);

        // Everything expected must have been observed
        chk("bus_left", 32'(exp_bus.size()), 0);
        chk("vr_left",  32'(exp_vr.size()),  0);
        chk("cmp_left", 32'(exp_cmp.size()), 0);
        chk("rv_left",  32'(rv_q.size()),    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vector_ls_seq
`default_nettype wire
